// File: rtl/exe_md_stage_pkg.sv
// -----------------------------------------------------------------------------
// exe_md_stage_pkg
// Shared definitions for the EXE stage with multiply/divide support:
//   - md_op_t    : encoding of the emd_op field
//   - md_state_t : IDLE/RUN state of the iterative multiply/divide unit
//   - ALU_*      : ealuc operation codes understood by alu
//   - helpers classifying md_op_t values
// -----------------------------------------------------------------------------
package exe_md_stage_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MFHI  = 3'd5,
      MD_MFLO  = 3'd6,
      MD_RSVD  = 3'd7   // behaves exactly like MD_NONE
   } md_op_t;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_RUN  = 1'b1
   } md_state_t;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_AND = 4'b0001;
   localparam logic [3:0] ALU_OR  = 4'b0101;
   localparam logic [3:0] ALU_XOR = 4'b0010;
   localparam logic [3:0] ALU_LUI = 4'b0110;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1111;

   // Operations that start an iteration of the multiply/divide unit.
   function automatic logic md_is_arith(input md_op_t op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   // Operations that depend on the multiply/divide unit (start it or read HI/LO).
   function automatic logic md_uses_unit(input md_op_t op);
      return md_is_arith(op) || (op == MD_MFHI) || (op == MD_MFLO);
   endfunction

endpackage

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Combinational integer ALU.
//   i_a    : operand A (low 5 bits are the shift amount for shifts)
//   i_b    : operand B (value being shifted for shifts)
//   i_aluc : operation code (ALU_* in exe_md_stage_pkg)
//   o_r    : result
// -----------------------------------------------------------------------------
module alu
   import exe_md_stage_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic [3:0]   i_aluc,
   output logic [W-1:0] o_r
);

   logic [4:0] w_sa;
   assign w_sa = i_a[4:0];

   always_comb begin
      // NOTE: o_r gets a value on every path (default first) so no latch is inferred.
      o_r = i_a + i_b;
      case (i_aluc)
         ALU_ADD: o_r = i_a + i_b;
         ALU_SUB: o_r = i_a - i_b;
         ALU_AND: o_r = i_a & i_b;
         ALU_OR:  o_r = i_a | i_b;
         ALU_XOR: o_r = i_a ^ i_b;
         ALU_LUI: o_r = i_b << (W / 2);
         ALU_SLL: o_r = i_b << w_sa;
         ALU_SRL: o_r = i_b >> w_sa;
         ALU_SRA: o_r = $signed(i_b) >>> w_sa;
         default: o_r = i_a + i_b;
      endcase
   end

endmodule

// File: rtl/exe_md_stage_md_unit.sv
// -----------------------------------------------------------------------------
// md_unit
// Iterative multiply/divide engine taking exactly W RUN cycles per operation.
// Works on operand magnitudes (shift-add multiply, restoring divide) and
// applies the signs when HI/LO are written on the final RUN edge.
//   clk, rst : clock, asynchronous active-high reset (aborts any operation)
//   i_issue  : start i_op on i_a/i_b (only honoured in IDLE)
//   i_op     : MD_MULT, MD_MULTU, MD_DIV or MD_DIVU
//   i_a, i_b : multiplicand/multiplier or dividend/divisor
//   o_busy   : unit is in RUN
//   o_hi     : HI register (product high half / remainder)
//   o_lo     : LO register (product low half / quotient)
// -----------------------------------------------------------------------------
module md_unit
   import exe_md_stage_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_issue,
   input  md_op_t       i_op,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic         o_busy,
   output logic [W-1:0] o_hi,
   output logic [W-1:0] o_lo
);

   localparam int CNT_W = $clog2(W + 1);

   md_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_is_div;
   logic             r_neg_q;   // negate product / quotient at the end
   logic             r_neg_r;   // negate remainder at the end
   logic             r_dz;      // division by zero
   logic [W-1:0]     r_acc_hi;  // product high half / partial remainder
   logic [W-1:0]     r_acc_lo;  // multiplier bits / dividend bits -> quotient
   logic [W-1:0]     r_opnd;    // multiplicand / divisor magnitude
   logic [W-1:0]     r_hi;
   logic [W-1:0]     r_lo;

   // Operand preparation at issue
   logic         w_signed, w_div_op, w_a_neg, w_b_neg;
   logic [W-1:0] w_a_mag, w_b_mag;

   assign w_signed = (i_op == MD_MULT) || (i_op == MD_DIV);
   assign w_div_op = (i_op == MD_DIV)  || (i_op == MD_DIVU);
   assign w_a_neg  = w_signed & i_a[W-1];
   assign w_b_neg  = w_signed & i_b[W-1];
   assign w_a_mag  = w_a_neg ? -i_a : i_a;
   assign w_b_mag  = w_b_neg ? -i_b : i_b;

   // One shift-add multiply step: add the multiplicand when the current
   // multiplier bit is set, then shift the {hi,lo} pair right by one.
   logic [W:0]   w_sum;
   logic [W-1:0] w_mul_hi, w_mul_lo;

   assign w_sum    = {1'b0, r_acc_hi} + {1'b0, (r_acc_lo[0] ? r_opnd : '0)};
   assign w_mul_hi = w_sum[W:1];
   assign w_mul_lo = {w_sum[0], r_acc_lo[W-1:1]};

   // One restoring divide step: shift the next dividend bit into the partial
   // remainder and subtract the divisor when it fits.
   logic [W:0]   w_shift;
   logic         w_ge;
   logic [W-1:0] w_sub, w_div_hi, w_div_lo;

   assign w_shift  = {r_acc_hi, r_acc_lo[W-1]};
   assign w_ge     = (w_shift >= {1'b0, r_opnd});
   assign w_sub    = w_shift[W-1:0] - r_opnd;
   assign w_div_hi = w_ge ? w_sub : w_shift[W-1:0];
   assign w_div_lo = {r_acc_lo[W-2:0], w_ge};

   logic [W-1:0] w_nxt_hi, w_nxt_lo;
   assign w_nxt_hi = r_is_div ? w_div_hi : w_mul_hi;
   assign w_nxt_lo = r_is_div ? w_div_lo : w_mul_lo;

   // Sign correction applied to the final step's result. With a zero divisor
   // the restoring loop already leaves |dividend| as remainder, so restoring
   // the dividend's sign yields the dividend; only LO needs forcing.
   logic [2*W-1:0] w_prod, w_prod_fix;
   logic [W-1:0]   w_quo, w_rem, w_fin_hi, w_fin_lo;

   assign w_prod     = {w_nxt_hi, w_nxt_lo};
   assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
   assign w_quo      = r_dz ? '1 : (r_neg_q ? -w_nxt_lo : w_nxt_lo);
   assign w_rem      = r_neg_r ? -w_nxt_hi : w_nxt_hi;
   assign w_fin_hi   = r_is_div ? w_rem : w_prod_fix[2*W-1:W];
   assign w_fin_lo   = r_is_div ? w_quo : w_prod_fix[W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      if (rst) begin
         r_state  <= MD_IDLE;
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_dz     <= 1'b0;
         r_acc_hi <= '0;
         r_acc_lo <= '0;
         r_opnd   <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         case (r_state)
            MD_IDLE: begin
               if (i_issue) begin
                  r_state  <= MD_RUN;
                  r_cnt    <= CNT_W'(W);
                  r_is_div <= w_div_op;
                  r_neg_q  <= w_a_neg ^ w_b_neg;
                  r_neg_r  <= w_a_neg;
                  r_dz     <= w_div_op && (i_b == '0);
                  r_acc_hi <= '0;
                  r_acc_lo <= w_a_mag;
                  r_opnd   <= w_b_mag;
               end
            end
            MD_RUN: begin
               r_acc_hi <= w_nxt_hi;
               r_acc_lo <= w_nxt_lo;
               r_cnt    <= r_cnt - 1'b1;
               if (r_cnt == CNT_W'(1)) begin
                  r_hi    <= w_fin_hi;
                  r_lo    <= w_fin_lo;
                  r_state <= MD_IDLE;
               end
            end
            default: r_state <= MD_IDLE;
         endcase
      end
   end

   assign o_busy = (r_state == MD_RUN);
   assign o_hi   = r_hi;
   assign o_lo   = r_lo;

endmodule

// File: rtl/exe_md_stage.sv
// -----------------------------------------------------------------------------
// exe_md_stage
// EXE pipeline stage with ALU, jump-and-link, and an iterative multiply/divide
// unit with HI/LO, followed by the EX/MEM pipeline register.
//   clk, rst      : clock, asynchronous active-high reset
//   ea, eb        : register operands
//   eimm          : extended immediate (eimm[10:6] = shift amount)
//   epc4          : PC+4 of the instruction
//   ern0          : destination register number
//   ealuc         : ALU operation code
//   ealuimm       : B operand is eimm
//   eshift        : A operand is the shift amount
//   ejal          : jump-and-link (result epc4+8, destination all ones)
//   ewreg         : GPR write enable
//   evalid        : an instruction is present
//   emd_op        : multiply/divide operation (md_op_t)
//   estall        : current instruction cannot retire this cycle
//   md_busy       : multiply/divide unit is iterating
//   malu/mrn/mwreg: EX/MEM result, destination, write enable
// -----------------------------------------------------------------------------
module exe_md_stage
   import exe_md_stage_pkg::*;
#(
   parameter int W    = 32,
   parameter int RN_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [W-1:0]    ea,
   input  logic [W-1:0]    eb,
   input  logic [W-1:0]    eimm,
   input  logic [W-1:0]    epc4,
   input  logic [RN_W-1:0] ern0,
   input  logic [3:0]      ealuc,
   input  logic            ealuimm,
   input  logic            eshift,
   input  logic            ejal,
   input  logic            ewreg,
   input  logic            evalid,
   input  logic [2:0]      emd_op,
   output logic            estall,
   output logic            md_busy,
   output logic [W-1:0]    malu,
   output logic [RN_W-1:0] mrn,
   output logic            mwreg
);

   md_op_t       w_op;
   logic [W-1:0] w_alu_a, w_alu_b, w_alu_r, w_result, w_hi, w_lo;
   logic         w_md_busy, w_accept, w_issue;

   assign w_op    = md_op_t'(emd_op);
   assign w_alu_a = eshift  ? {{(W-5){1'b0}}, eimm[10:6]} : ea;
   assign w_alu_b = ealuimm ? eimm : eb;

   alu #(.W(W)) u_alu (
      .i_a    (w_alu_a),
      .i_b    (w_alu_b),
      .i_aluc (ealuc),
      .o_r    (w_alu_r)
   );

   // Anything touching the MD unit waits while it iterates; other instructions
   // flow past it.
   assign estall   = evalid & w_md_busy & md_uses_unit(w_op);
   assign w_accept = evalid & ~estall;
   assign w_issue  = w_accept & md_is_arith(w_op);

   md_unit #(.W(W)) u_md_unit (
      .clk     (clk),
      .rst     (rst),
      .i_issue (w_issue),
      .i_op    (w_op),
      .i_a     (ea),
      .i_b     (eb),
      .o_busy  (w_md_busy),
      .o_hi    (w_hi),
      .o_lo    (w_lo)
   );

   assign md_busy = w_md_busy;

   always_comb begin
      w_result = w_alu_r;
      if (ejal)
         w_result = epc4 + W'(8);
      if (w_op == MD_MFHI)
         w_result = w_hi;
      else if (w_op == MD_MFLO)
         w_result = w_lo;
   end

   logic [W-1:0]    r_malu;
   logic [RN_W-1:0] r_mrn;
   logic            r_mwreg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_malu  <= '0;
         r_mrn   <= '0;
         r_mwreg <= 1'b0;
      end else if (w_accept) begin
         r_malu  <= w_result;
         r_mrn   <= ejal ? '1 : ern0;
         // mult/div leave through EX/MEM without writing a GPR
         r_mwreg <= ewreg & ~md_is_arith(w_op);
      end else begin
         r_malu  <= '0;
         r_mrn   <= '0;
         r_mwreg <= 1'b0;
      end
   end

   assign malu  = r_malu;
   assign mrn   = r_mrn;
   assign mwreg = r_mwreg;

endmodule
